// File: rtl/out_port_if.sv
// CPU-side bundle for the output port: push strobe/data plus serial line and FIFO status.
// The CPU drives through the master modport; out_port implements the slave side.
interface out_port_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          load;
  logic [7:0]    in;
  logic          tx;
  logic          busy;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    last;

  modport master (
    output load, in,
    input  tx, busy, empty, full, count, overflow, last
  );

  modport slave (
    input  load, in,
    output tx, busy, empty, full, count, overflow, last
  );
endinterface

// File: rtl/out_port.sv
// CPU output stage: bytes pushed by the OUT strobe are queued and sent as 8N1 serial frames.
// The CPU never stalls; a push into a full queue is dropped and flagged in a sticky bit.
module out_port #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  out_port_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [TW-1:0] TimerMax = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          busy_q;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic [7:0]    last_q;

  logic bit_end;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    bit_end    = (timer_q == TimerMax);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DepthCnt);
    // A pop happens exactly when the FSM enters START, from IDLE or at the end of STOP.
    pop        = !fifo_empty && ((state_q == StIdle) || ((state_q == StStop) && bit_end));
    // A same-cycle pop frees a slot, so a full queue can still accept.
    push       = bus.load && (!fifo_full || pop);
    drop       = bus.load && !push;
  end

  // Storage is not reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_q     <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        last_q   <= bus.in;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // tx and busy are registered alongside the state so the line never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          timer_q <= '0;
          if (pop) begin
            state_q <= StStart;
            shift_q <= mem_q[rd_ptr_q];
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StStart: begin
          if (bit_end) begin
            timer_q   <= '0;
            state_q   <= StData;
            bit_idx_q <= 3'd0;
            tx_q      <= shift_q[0];
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StData: begin
          if (bit_end) begin
            timer_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StStop: begin
          if (bit_end) begin
            timer_q <= '0;
            if (pop) begin
              state_q <= StStart;
              shift_q <= mem_q[rd_ptr_q];
              tx_q    <= 1'b0;
            end else begin
              state_q <= StIdle;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          timer_q <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.empty    = fifo_empty;
  assign bus.full     = fifo_full;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.last     = last_q;

endmodule

// File: doc/out_port.md
# out_port

Output stage for the 8-bit CPU. When the control strobe for the output instruction is asserted, the block captures the byte on the data bus into a small FIFO. It then transmits each queued byte as an asynchronous serial frame: start bit, 8 data bits LSB first, stop bit. This replaces simulation-only printing of register A with a synthesizable output path, and the CPU never stalls on output.

## Interface

Parameters:
- DEPTH, 4: FIFO entries; must be a power of two, at least 2.
- CLKS_PER_BIT, 4: clock cycles per serial bit; at least 1.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high; sampled on the rising edge of clk.
- load, input, 1: push request; driven by the CPU output strobe (c_oi).
- in, input, 8: byte to push; register A value on the shared bus.
- tx, output, 1: serial line; idles high.
- busy, output, 1: high while a frame is on tx.
- empty, output, 1: FIFO holds 0 entries.
- full, output, 1: FIFO holds DEPTH entries.
- count, output, clog2(DEPTH)+1: current FIFO occupancy.
- overflow, output, 1: sticky; set when a push is dropped.
- last, output, 8: most recently accepted byte.

## Operation

- Reset values: tx=1, busy=0, empty=1, full=0, count=0, overflow=0, last=8'h00, FSM=IDLE, FIFO pointers=0. Reset overrides every other input in the same cycle, including mid-frame: tx returns to 1 on the next edge.
- Push: when load=1, the FIFO accepts in unless it is full after this cycle's pop is counted.
  - An accepted push writes the FIFO entry and updates last.
  - A rejected push sets overflow and leaves the FIFO and last unchanged.
- Pop: taken only when the FSM enters START.
- Simultaneous push and pop while full: both succeed and count is unchanged.
- Pointers: log2(DEPTH) bits each, wrap modulo DEPTH. count increments on push only, decrements on pop only.
- load is level-sampled, so holding it for k cycles pushes k bytes. The CPU strobe lasts one cycle per OUT.
- FSM states and transitions:
  - IDLE: go to START when not empty (pop).
  - START: tx=0; after CLKS_PER_BIT cycles go to DATA.
  - DATA: tx = shift[0]; every CLKS_PER_BIT cycles shift right; after 8 bits go to STOP.
  - STOP: tx=1; after CLKS_PER_BIT cycles go to START if not empty (pop, no idle gap), otherwise go to IDLE.
- Bit timer: runs from 0 to CLKS_PER_BIT-1 and resets on every bit boundary. The bit index runs from 0 to 7.
- busy=1 in START, DATA and STOP.

## Timing

- A push sampled at edge N is visible on count and empty after edge N.
- From IDLE, the FSM sees empty=0 at edge N+1, pops, and drives tx=0 from edge N+1. Push-to-start-bit latency is 2 edges.
- Frame length is exactly 10·CLKS_PER_BIT cycles.
- Queued bytes are sent back-to-back with no idle cycles between frames.
- The popped byte is latched into the shift register at the START transition. Later FIFO writes do not affect the frame in flight.
- full and empty are registered-consistent with count in the same cycle, never lagging.

## Test plan

1. Reset, then load=1 for one cycle with in=8'hA5, CLKS_PER_BIT=4.
   - tx=1 until 2 edges after the push, then bits 0,1,0,1,0,0,1,0,1,1 each held 4 cycles.
   - busy high for 40 cycles; last=A5; empty=1 after the pop.
2. Push 8'h01, 8'h02, 8'h03 on consecutive cycles.
   - Three frames sent back-to-back in order with no idle cycles.
   - tx=1 and busy=0 only after cycle 2+120.
3. With the transmitter busy, push DEPTH+1 more bytes.
   - full=1 after DEPTH of them.
   - The extra byte is dropped, overflow=1, last equals the last accepted byte.
4. While full, push on the exact cycle STOP pops the next entry.
   - The push is accepted, count stays DEPTH, overflow unchanged.
5. Assert reset in the middle of the DATA bits of a frame.
   - Next edge: tx=1, busy=0, count=0, overflow=0, last=00.
   - No further frame is sent.
6. Run with CLKS_PER_BIT=1 and push 8'hFF, 8'h00.
   - Frame bits are 1 cycle each: 0, eight 1s, 1, then 0, eight 0s, 1.
   - Total 20 cycles.
